// File: rtl/aap_regfile_pkg.sv
// rtl/aap_regfile_pkg.sv - shared FSM encoding and default sizes for the AAP multi-port register file
// STATE_HALTED normally comes from aap.vh; the fallback below only applies when that header is absent.
`ifndef STATE_HALTED
`define STATE_HALTED 3'b100
`endif

package aap_regfile_pkg;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   localparam int RF_DW    = 16;
   localparam int RF_AW    = 6;
   localparam int RF_NREGS = 64;
   localparam int RF_NRD   = 3;
   localparam int RF_NWR   = 3;

   // Index width for a port selector; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aap_regfile_wrsel.sv
// rtl/aap_regfile_wrsel.sv - per-register write select: winning port, hit, conflict and bad-regnum detect
module aap_regfile_wrsel
   import aap_regfile_pkg::*;
#(
   parameter int AW    = RF_AW,
   parameter int NREGS = RF_NREGS,
   parameter int NP    = RF_NWR + 1,
   parameter int IW    = idx_w(RF_NWR + 1)
) (
   input  logic [NP-1:0]       en_i,
   input  logic [NP*AW-1:0]    regnum_i,
   output logic [NREGS-1:0]    hit_o,
   output logic [NREGS*IW-1:0] win_o,
   output logic                conflict_o,
   output logic                bad_o
);

   always_comb begin
      hit_o      = '0;
      win_o      = '0;
      conflict_o = 1'b0;
      bad_o      = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (en_i[p] && int'(regnum_i[p*AW +: AW]) >= NREGS) begin
            bad_o = 1'b1;
         end
         for (int q = p + 1; q < NP; q++) begin
            if (en_i[p] && en_i[q] && regnum_i[p*AW +: AW] == regnum_i[q*AW +: AW]
                && int'(regnum_i[p*AW +: AW]) < NREGS) begin
               conflict_o = 1'b1;
            end
         end
      end
      // Ascending scan so the highest-numbered enabled port overwrites earlier winners.
      for (int r = 0; r < NREGS; r++) begin
         for (int p = 0; p < NP; p++) begin
            if (en_i[p] && int'(regnum_i[p*AW +: AW]) == r) begin
               hit_o[r]            = 1'b1;
               win_o[r*IW +: IW]   = IW'(p);
            end
         end
      end
   end

endmodule

// File: rtl/aap_regfile_mp.sv
// rtl/aap_regfile_mp.sv - parametrised multi-port register file with sequenced clear and error flags
// Optional write-through bypass on all read ports when AAP_REGFILE_BYPASS_EN is defined.
module aap_regfile_mp
   import aap_regfile_pkg::*;
#(
   parameter int DW    = RF_DW,
   parameter int AW    = RF_AW,
   parameter int NREGS = RF_NREGS,
   parameter int NRD   = RF_NRD,
   parameter int NWR   = RF_NWR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        state,
   input  logic [NRD*AW-1:0] rd_regnum,
   output logic [NRD*DW-1:0] rd_data,
   input  logic [NWR*AW-1:0] wr_regnum,
   input  logic [NWR*DW-1:0] wr_data,
   input  logic [NWR-1:0]    wr_we,
   input  logic [AW-1:0]     dbg_rregnum,
   output logic [DW-1:0]     dbg_rdata,
   input  logic [AW-1:0]     dbg_wregnum,
   input  logic [DW-1:0]     dbg_wdata,
   input  logic              dbg_we,
   input  logic              clr_req,
   output logic              ready,
   output logic              wr_conflict,
   output logic              bad_regnum
);

   localparam int NP = NWR + 1;
   localparam int IW = idx_w(NP);
   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   rf_state_e         fsm_q, fsm_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic              conflict_q, bad_q;
   logic [DW-1:0]     mem_q [NREGS];

   logic              in_ready;
   logic              halted;
   logic [NP-1:0]     act_en;
   logic [NP*AW-1:0]  act_rn;
   logic [NP*DW-1:0]  act_data;
   logic [NREGS-1:0]  sel_hit;
   logic [NREGS*IW-1:0] sel_win;
   logic              sel_conflict;
   logic              sel_bad;

   assign in_ready = (fsm_q == RF_READY);
   assign halted   = (state == `STATE_HALTED);
   assign ready    = in_ready;

   // Debug port sits above the normal ports; the two groups are never active together.
   assign act_rn   = {dbg_wregnum, wr_regnum};
   assign act_data = {dbg_wdata, wr_data};
   assign act_en   = !in_ready ? '0 :
                     halted    ? {dbg_we, {NWR{1'b0}}} : {1'b0, wr_we};

   aap_regfile_wrsel #(
      .AW    (AW),
      .NREGS (NREGS),
      .NP    (NP),
      .IW    (IW)
   ) u_wrsel (
      .en_i       (act_en),
      .regnum_i   (act_rn),
      .hit_o      (sel_hit),
      .win_o      (sel_win),
      .conflict_o (sel_conflict),
      .bad_o      (sel_bad)
   );

   always_comb begin
      fsm_d     = fsm_q;
      clr_idx_d = clr_idx_q;
      case (fsm_q)
         RF_CLEAR: begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
               fsm_d     = RF_READY;
               clr_idx_d = '0;
            end
         end
         RF_READY: begin
            if (clr_req) begin
               fsm_d     = RF_CLEAR;
               clr_idx_d = '0;
            end
         end
         default: begin
            fsm_d     = RF_CLEAR;
            clr_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q      <= RF_CLEAR;
         clr_idx_q  <= '0;
         conflict_q <= 1'b0;
         bad_q      <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         clr_idx_q  <= clr_idx_d;
         conflict_q <= sel_conflict;
         bad_q      <= sel_bad;
      end
   end

   assign wr_conflict = conflict_q;
   assign bad_regnum  = bad_q;

   // Storage has no reset so it can map onto RAM; the clear sequence initialises it.
   always_ff @(posedge clk) begin
      if (fsm_q == RF_CLEAR) begin
         mem_q[clr_idx_q] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (sel_hit[r]) begin
               mem_q[r] <= act_data[int'(sel_win[r*IW +: IW])*DW +: DW];
            end
         end
      end
   end

   function automatic logic [DW-1:0] read_reg(input logic [AW-1:0] rn);
      logic [DW-1:0] v;
      v = '0;
      if (in_ready && int'(rn) < NREGS) begin
         v = mem_q[rn];
`ifdef AAP_REGFILE_BYPASS_EN
         if (sel_hit[rn]) begin
            v = act_data[int'(sel_win[int'(rn)*IW +: IW])*DW +: DW];
         end
`endif
      end
      return v;
   endfunction

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_data[i*DW +: DW] = read_reg(rd_regnum[i*AW +: AW]);
      end
      dbg_rdata = read_reg(dbg_rregnum);
   end

endmodule

// File: tb/tb_aap_regfile_mp.sv
// tb/tb_aap_regfile_mp.sv - randomized model-checked bench for aap_regfile_mp (NREGS=40 to reach bad regnums)
`ifndef STATE_HALTED
`define STATE_HALTED 3'b100
`endif

module tb_aap_regfile_mp;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int NREGS = 40;
   localparam int NRD = 3;
   localparam int NWR = 3;
   localparam logic [2:0] ST_HALT = `STATE_HALTED;
   localparam logic [2:0] ST_RUN  = `STATE_HALTED ^ 3'b001;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0]        state;
   logic [NRD*AW-1:0] rd_regnum;
   logic [NRD*DW-1:0] rd_data;
   logic [NWR*AW-1:0] wr_regnum;
   logic [NWR*DW-1:0] wr_data;
   logic [NWR-1:0]    wr_we;
   logic [AW-1:0]     dbg_rregnum;
   logic [DW-1:0]     dbg_rdata;
   logic [AW-1:0]     dbg_wregnum;
   logic [DW-1:0]     dbg_wdata;
   logic              dbg_we;
   logic              clr_req;
   logic              ready;
   logic              wr_conflict;
   logic              bad_regnum;

   aap_regfile_mp #(.DW(DW), .AW(AW), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .clk(clk), .rst(rst), .state(state),
      .rd_regnum(rd_regnum), .rd_data(rd_data),
      .wr_regnum(wr_regnum), .wr_data(wr_data), .wr_we(wr_we),
      .dbg_rregnum(dbg_rregnum), .dbg_rdata(dbg_rdata),
      .dbg_wregnum(dbg_wregnum), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
      .clr_req(clr_req), .ready(ready),
      .wr_conflict(wr_conflict), .bad_regnum(bad_regnum)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [NREGS];
   bit  m_ready;
   int  m_cnt;
   bit  e_conf, e_bad;
   int  n_pass = 0;
   int  n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic void get_port(input int p, output bit en,
                                    output logic [AW-1:0] rn, output logic [DW-1:0] d);
      bit h;
      h = (state == ST_HALT);
      if (p == NWR) begin
         en = m_ready && h && dbg_we;
         rn = dbg_wregnum;
         d  = dbg_wdata;
      end else begin
         en = m_ready && !h && wr_we[p];
         rn = wr_regnum[p*AW +: AW];
         d  = wr_data[p*DW +: DW];
      end
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] rn);
      logic [DW-1:0] v;
      bit en;
      logic [AW-1:0] prn;
      logic [DW-1:0] pd;
      if (!m_ready || rn >= NREGS) return '0;
      v = mem[rn];
`ifdef AAP_REGFILE_BYPASS_EN
      for (int p = 0; p <= NWR; p++) begin
         get_port(p, en, prn, pd);
         if (en && prn == rn) v = pd;
      end
`endif
      return v;
   endfunction

   task automatic compare();
      chk("ready", {31'd0, ready}, {31'd0, m_ready});
      chk("wr_conflict", {31'd0, wr_conflict}, {31'd0, e_conf});
      chk("bad_regnum", {31'd0, bad_regnum}, {31'd0, e_bad});
      for (int i = 0; i < NRD; i++)
         chk($sformatf("rd_data[%0d]", i), {16'd0, rd_data[i*DW +: DW]},
             {16'd0, exp_rd(rd_regnum[i*AW +: AW])});
      chk("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, exp_rd(dbg_rregnum)});
   endtask

   // Apply one clock edge to the model: ports in ascending order so the last writer wins.
   task automatic model_edge();
      int hits [NREGS];
      bit en, conf, bad;
      logic [AW-1:0] rn;
      logic [DW-1:0] d;
      if (rst) return;
      if (m_ready) begin
         conf = 0;
         bad = 0;
         foreach (hits[r]) hits[r] = 0;
         for (int p = 0; p <= NWR; p++) begin
            get_port(p, en, rn, d);
            if (en) begin
               if (rn >= NREGS) bad = 1;
               else begin
                  hits[rn]++;
                  if (hits[rn] > 1) conf = 1;
                  mem[rn] = d;
               end
            end
         end
         e_conf = conf;
         e_bad = bad;
         if (clr_req) begin
            m_ready = 0;
            m_cnt = NREGS;
         end
      end else begin
         e_conf = 0;
         e_bad = 0;
         m_cnt--;
         if (m_cnt == 0) begin
            foreach (mem[r]) mem[r] = '0;
            m_ready = 1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_we = '0;
      dbg_we = 1'b0;
      clr_req = 1'b0;
      state = ST_RUN;
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1;
      m_ready = 0;
      m_cnt = NREGS;
      e_conf = 0;
      e_bad = 0;
      repeat (hold) step();
      rst = 1'b0;
   endtask

   task automatic wait_clear(input string name);
      repeat (NREGS - 1) step();
      chk({name, "_ready_low_at_n-1"}, {31'd0, ready}, 32'd0);
      step();
      chk({name, "_ready_high_at_n"}, {31'd0, ready}, 32'd1);
   endtask

   task automatic rand_inputs();
      state = ($urandom_range(0, 4) == 0) ? ST_HALT : ST_RUN;
      wr_we = NWR'($urandom);
      dbg_we = 1'($urandom);
      for (int p = 0; p < NWR; p++) begin
         wr_regnum[p*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         wr_data[p*DW +: DW] = DW'($urandom);
      end
      for (int i = 0; i < NRD; i++)
         rd_regnum[i*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      dbg_wregnum = $urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 7));
      dbg_wdata = DW'($urandom);
      dbg_rregnum = AW'($urandom_range(0, 45));
      clr_req = ($urandom_range(0, 59) == 0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      rd_regnum = '0;
      wr_regnum = '0;
      wr_data = '0;
      dbg_rregnum = '0;
      dbg_wregnum = '0;
      dbg_wdata = '0;
      foreach (mem[r]) mem[r] = '0;

      // Reset and initial clear, with write traffic that must be ignored.
      do_reset(2);
      chk("reset_ready", {31'd0, ready}, 32'd0);
      for (int c = 0; c < NREGS - 1; c++) begin
         rand_inputs();
         state = ST_RUN;
         step();
      end
      idle();
      chk("init_ready_low", {31'd0, ready}, 32'd0);
      step();
      chk("init_ready_high", {31'd0, ready}, 32'd1);
      for (int r = 0; r < NREGS; r += NRD) begin
         for (int i = 0; i < NRD; i++) rd_regnum[i*AW +: AW] = AW'((r + i) % NREGS);
         step();
      end

      // Conflict: port0 and port2 on reg5, port2 wins.
      wr_we = 3'b101;
      wr_regnum = {AW'(5), AW'(0), AW'(5)};
      wr_data = {16'h2222, 16'h0000, 16'h1111};
      step();
      idle();
      rd_regnum[0 +: AW] = AW'(5);
      #1;
      chk("conflict_winner", {16'd0, rd_data[0 +: DW]}, 32'h2222);
      chk("conflict_pulse", {31'd0, wr_conflict}, 32'd1);
      step();
      chk("conflict_drop", {31'd0, wr_conflict}, 32'd0);

      // Last valid regnum written, regnum == NREGS dropped.
      wr_we = 3'b011;
      wr_regnum = {AW'(0), AW'(NREGS - 1), AW'(NREGS)};
      wr_data = {16'h0000, 16'h3939, 16'hDEAD};
      step();
      idle();
      rd_regnum = {AW'(0), AW'(NREGS), AW'(NREGS - 1)};
      #1;
      chk("bad_pulse", {31'd0, bad_regnum}, 32'd1);
      chk("top_reg_written", {16'd0, rd_data[0 +: DW]}, 32'h3939);
      chk("oob_read_zero", {16'd0, rd_data[DW +: DW]}, 32'h0);
      chk("bad_no_conflict", {31'd0, wr_conflict}, 32'd0);
      step();
      chk("bad_drop", {31'd0, bad_regnum}, 32'd0);

      // Halted: only the debug write lands.
      state = ST_HALT;
      wr_we = 3'b111;
      wr_regnum = {AW'(3), AW'(2), AW'(1)};
      wr_data = {16'h3333, 16'h2222, 16'h1111};
      dbg_we = 1'b1;
      dbg_wregnum = AW'(7);
      dbg_wdata = 16'hBEEF;
      step();
      idle();
      dbg_rregnum = AW'(7);
      rd_regnum = {AW'(3), AW'(2), AW'(1)};
      #1;
      chk("halted_dbg_write", {16'd0, dbg_rdata}, 32'hBEEF);
      chk("halted_port_ignored", {16'd0, rd_data[0 +: DW]}, 32'h0);
      step();

      // Same-cycle read of an in-flight write.
      wr_we = 3'b001;
      wr_regnum = {AW'(0), AW'(0), AW'(9)};
      wr_data = {16'h0, 16'h0, 16'h1234};
      step();
      wr_data = {16'h0, 16'h0, 16'hA5A5};
      rd_regnum[0 +: AW] = AW'(9);
      #1;
`ifdef AAP_REGFILE_BYPASS_EN
      chk("bypass_same_cycle", {16'd0, rd_data[0 +: DW]}, 32'hA5A5);
`else
      chk("nobypass_same_cycle", {16'd0, rd_data[0 +: DW]}, 32'h1234);
`endif
      step();
      idle();
      #1;
      chk("write_next_cycle", {16'd0, rd_data[0 +: DW]}, 32'hA5A5);

      // Fill, then clr_req together with a port0 write.
      for (int r = 0; r < NREGS; r += NWR) begin
         wr_we = 3'b111;
         for (int p = 0; p < NWR; p++) begin
            wr_regnum[p*AW +: AW] = AW'((r + p) % NREGS);
            wr_data[p*DW +: DW] = DW'(16'h100 + r + p);
         end
         step();
      end
      wr_we = 3'b001;
      wr_regnum = {AW'(0), AW'(0), AW'(3)};
      wr_data = {16'h0, 16'h0, 16'h3333};
      clr_req = 1'b1;
      step();
      idle();
      wait_clear("clr_req");
      rd_regnum = {AW'(1), AW'(9), AW'(3)};
      #1;
      chk("cleared_reg3", {16'd0, rd_data[0 +: DW]}, 32'h0);

      // Reset in the middle of a clear restarts it from scratch.
      clr_req = 1'b1;
      step();
      idle();
      repeat (10) step();
      do_reset(1);
      wait_clear("midclear_rst");

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         rand_inputs();
         step();
      end
      idle();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
